// File: rtl/shift_seq.sv
// Shift-count sequencer feeding the SHM shift matrix: reduces a signed 10-bit
// count (saturate or mod-72) and issues it as handshaked steps of at most 35.
module shift_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [0:9] count,
    input  logic       rot,
    input  logic       step_ready,
    output logic       busy,
    output logic       step_valid,
    output logic [0:5] step_amt,
    output logic       step_dir,
    output logic       done
);

    localparam logic [9:0] WORD_PAIR = 10'd72;
    localparam logic [9:0] STEP_MAX  = 10'd35;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] rem_q, rem_d;
    logic       dir_q, dir_d;
    logic       rot_q, rot_d;

    logic [9:0] count_v;
    logic [9:0] count_mag;
    logic [5:0] amt_w;
    logic       valid_w;
    logic       done_w;

    // Port is MSB-first (bit 0 = sign); the assignment keeps the sign as bit 9.
    assign count_v   = count;
    assign count_mag = count_v[9] ? (~count_v + 10'd1) : count_v;
    assign amt_w     = (rem_q > STEP_MAX) ? STEP_MAX[5:0] : rem_q[5:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        valid_w = 1'b0;
        done_w  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = count_v[9];
                    rot_d   = rot;
                    rem_d   = count_mag;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (rot_q && (rem_q >= WORD_PAIR)) begin
                    rem_d = rem_q - WORD_PAIR;
                end else if (!rot_q && (rem_q > WORD_PAIR)) begin
                    rem_d = WORD_PAIR;
                end else if (rem_q == 10'd0) begin
                    state_d = FIN;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                valid_w = 1'b1;
                if (step_ready) begin
                    rem_d = rem_q - {4'd0, amt_w};
                    if (rem_q <= STEP_MAX) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_w  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= 10'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
        end
    end

    // step_amt reads as zero outside STEP so idle/reset outputs are clean.
    assign busy       = (state_q != IDLE);
    assign step_valid = valid_w;
    assign step_amt   = valid_w ? amt_w : 6'd0;
    assign step_dir   = dir_q;
    assign done       = done_w;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: scoreboard of expected steps plus
// per-scenario latency, stall, and reset checks.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [0:9] count;
    logic       rot;
    logic       step_ready;
    logic       busy;
    logic       step_valid;
    logic [0:5] step_amt;
    logic       step_dir;
    logic       done;

    typedef struct packed {
        logic [5:0] amt;
        logic       dir;
    } step_t;

    step_t exp_q[$];
    int    total    = 0;
    int    bad      = 0;
    int    done_cnt = 0;

    shift_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .rot       (rot),
        .step_ready(step_ready),
        .busy      (busy),
        .step_valid(step_valid),
        .step_amt  (step_amt),
        .step_dir  (step_dir),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted step is popped and compared.
    always @(negedge clk) begin : monitor
        step_t e;
        if (done) done_cnt++;
        if (!reset && step_valid && step_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_step amt=%0d dir=%0d required none", step_amt, step_dir);
            end else begin
                e = exp_q.pop_front();
                if (step_amt !== e.amt || step_dir !== e.dir) begin
                    bad++;
                    $display("[TB] FAIL step amt=%0d dir=%0d required amt=%0d dir=%0d",
                             step_amt, step_dir, e.amt, e.dir);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog global timeout");
        $fatal(1, "[TB] global timeout");
    end

    // Independent model: reduce count and push the expected step sequence.
    task automatic expect_op(input int cnt, input bit r, output int prep, output int nst);
        int    m;
        step_t e;
        m    = (cnt < 0) ? -cnt : cnt;
        prep = 0;
        nst  = 0;
        if (r) begin
            while (m >= 72) begin
                m -= 72;
                prep++;
            end
        end else if (m > 72) begin
            m    = 72;
            prep = 1;
        end
        while (m > 0) begin
            e.amt = 6'((m > 35) ? 35 : m);
            e.dir = (cnt < 0);
            exp_q.push_back(e);
            m -= int'(e.amt);
            nst++;
        end
    endtask

    task automatic launch(input int cnt, input bit r);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 10'(cnt);
        rot   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // n counts negedges after the start-capture edge; done expected at exp_n.
    task automatic wait_done(input int exp_n, input string name);
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL %s_timeout done not seen within 300 cycles", name);
        end else begin
            if (n !== exp_n) begin
                bad++;
                $display("[TB] FAIL %s_latency got=%0d required=%0d", name, n, exp_n);
            end
            total++;
            if (exp_q.size() != 0 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s_at_done pending=%0d busy=%0b required pending=0 busy=1",
                         name, exp_q.size(), busy);
            end
            @(posedge clk);
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s_after_done busy=%0b done=%0b required 0 0", name, busy, done);
            end
        end
        exp_q.delete();
    endtask

    task automatic run_op(input int cnt, input bit r, input string name);
        int prep;
        int nst;
        expect_op(cnt, r, prep, nst);
        launch(cnt, r);
        wait_done(1 + prep + nst, name);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        count      = '0;
        rot        = 1'b0;
        step_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || step_amt !== 6'd0 || step_dir !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs busy=%0b valid=%0b amt=%0d dir=%0b done=%0b required all 0",
                     busy, step_valid, step_amt, step_dir, done);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 10'd5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_with_start busy=%0b required 0", busy);
        end
    endtask

    task automatic test_shift_single();
        step_ready = 1'b1;
        run_op(10, 1'b0, "shift10");
        run_op(3, 1'b0, "shift3");
    endtask

    task automatic test_saturate();
        int dc;
        step_ready = 1'b1;
        dc = done_cnt;
        run_op(-80, 1'b0, "sat_m80");
        total++;
        if (done_cnt - dc !== 1) begin
            bad++;
            $display("[TB] FAIL sat_done_pulses got=%0d required=1", done_cnt - dc);
        end
        run_op(-512, 1'b0, "sat_m512");
    endtask

    task automatic test_rotate();
        step_ready = 1'b1;
        run_op(511, 1'b1, "rot511");
        run_op(-512, 1'b1, "rot_m512");
        run_op(-100, 1'b1, "rot_m100");
    endtask

    task automatic test_zero();
        step_ready = 1'b1;
        run_op(0, 1'b0, "zero");
        run_op(144, 1'b1, "rot144");
    endtask

    task automatic test_stall();
        int  prep;
        int  nst;
        int  n;
        bit  seen;
        step_ready = 1'b0;
        expect_op(50, 1'b0, prep, nst);
        launch(50, 1'b0);
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (step_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        total++;
        if (!seen || n !== 1) begin
            bad++;
            $display("[TB] FAIL stall_first_valid seen=%0b at=%0d required seen=1 at=1", seen, n);
        end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            total++;
            if (step_valid !== 1'b1 || step_amt !== 6'd35 || step_dir !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stall_hold cyc=%0d valid=%0b amt=%0d dir=%0b busy=%0b required 1 35 0 1",
                         i, step_valid, step_amt, step_dir, busy);
            end
            @(posedge clk);
            #1;
            start = (i == 1);
            count = 10'd3;
        end
        step_ready = 1'b1;
        wait_done(2, "stall");
    endtask

    task automatic test_reset_mid();
        int prep;
        int nst;
        int n;
        int dc;
        bit seen;
        step_ready = 1'b1;
        expect_op(-100, 1'b0, prep, nst);
        launch(-100, 1'b0);
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (step_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL rmid_first_step not seen");
        end
        @(posedge clk);
        #1;
        reset      = 1'b1;
        step_ready = 1'b0;
        dc         = done_cnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || step_amt !== 6'd0 || step_dir !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_after_reset busy=%0b valid=%0b amt=%0d dir=%0b done=%0b required all 0",
                     busy, step_valid, step_amt, step_dir, done);
        end
        exp_q.delete();
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt !== dc) begin
            bad++;
            $display("[TB] FAIL rmid_no_done pulses=%0d required=0", done_cnt - dc);
        end
        step_ready = 1'b1;
        run_op(3, 1'b0, "rmid_restart");
    endtask

    task automatic test_back_to_back();
        int prep;
        int nst;
        int n;
        bit seen;
        step_ready = 1'b1;
        run_op(70, 1'b0, "b2b_70");
        expect_op(20, 1'b0, prep, nst);
        launch(20, 1'b0);
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        total++;
        if (!seen || n !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_20_done seen=%0b at=%0d required seen=1 at=2", seen, n);
        end
        start = 1'b1;
        count = 10'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_start_in_done busy=%0b required 0", busy);
        end
        exp_q.delete();
        run_op(-7, 1'b0, "b2b_m7");
    endtask

    initial begin
        test_reset();
        test_shift_single();
        test_saturate();
        test_rotate();
        test_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
